fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of a FIFO among NUM_REQ requesters.
- Grants one requester at a time for a bounded burst of up to MAX_BURST beats.
- Forwards the granted requester's data to the FIFO write port, with backpressure from the FIFO's full flag.
- Sits directly in front of the FIFO write side, in the FIFO's write clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 16, data width; equals the FIFO width.
- MAX_BURST, 8, maximum beats per grant (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
- din  input  NUM_REQ*DATA_WIDTH  requester data, packed; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant.
- ack  output  NUM_REQ  beat accepted this cycle (combinational).
- fifo_full  input  1  full flag from the FIFO.
- fifo_wen  output  1  FIFO write enable (combinational).
- fifo_din  output  DATA_WIDTH  FIFO write data (combinational mux).
- busy  output  1  high while in BURST.
- active_id  output  max(1,$clog2(NUM_REQ))  registered index of the granted requester.

Behaviour:

Reset (rst_n low, asynchronous):
- state=IDLE, gnt=0, active_id=0, rr_ptr=0, beat_cnt=0, busy=0.
- ack=0 and fifo_wen=0 follow from gnt=0.

State machine, 2 states:

IDLE:
- If req != 0, select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap mod NUM_REQ.
- Next edge: gnt=onehot(i), active_id=i, beat_cnt=0, state=BURST.
- ack=0 during IDLE; latency from req to gnt is 1 cycle.
- If req == 0, stay in IDLE.

BURST (id = active_id):
- ack[id] = req[id] & ~fifo_full; all other ack bits are 0.
- fifo_wen = ack[id]; fifo_din = din slice of id, even when fifo_wen=0.
- An ack beat increments beat_cnt.
- Release condition, evaluated every BURST cycle: (~req[id]) OR (ack[id] AND beat_cnt==MAX_BURST-1).
- On release, next edge: gnt=0, state=IDLE, rr_ptr=(id+1) mod NUM_REQ, beat_cnt=0.
- This gives exactly one dead IDLE cycle between bursts, including back-to-back regrant to the same requester.
- fifo_full high holds the burst: no ack, beat_cnt frozen, gnt held; it never causes release.
- A req[id] drop releases even if zero beats were transferred.
- Requests from non-granted requesters are ignored until IDLE; they are not latched.

Requester obligations:
- Hold din stable while req high.
- A beat is consumed only on the cycle its ack=1.

Other rules:
- beat_cnt width: max(1,$clog2(MAX_BURST)).
- MAX_BURST=1: every beat releases.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Never write to the FIFO when fifo_full=1.
- Reset asserted mid-burst: gnt, fifo_wen and ack drop immediately (asynchronously). The burst is abandoned; no partial-state recovery.
- Invariants: gnt is 0 or one-hot; popcount(ack)<=1; fifo_wen == |ack; busy == |gnt.

Test Plan:
1. Reset: drive req=4'b1111 and pull rst_n low mid-burst at a non-edge time -> gnt=0, fifo_wen=0 immediately. After release, first grant is to requester 0 (gnt=4'b0001) one cycle after the first edge.
2. Single requester: req=4'b0100 held, din[2]=0x1000+n, fifo_full=0.
   - gnt=4'b0100 at cycle 1; 8 consecutive ack/fifo_wen with fifo_din 0x1000..0x1007.
   - gnt=0 for 1 cycle, then gnt=4'b0100 again.
3. All request continuously -> grant sequence 0,1,2,3,0, each exactly 8 beats, with one idle cycle between grants.
4. Backpressure: fifo_full=1 for 3 cycles after beat 2 of a burst -> fifo_wen=0 and gnt held for those cycles. Burst resumes and completes at exactly 8 total beats; no data duplicated or skipped.
5. Early drop: requester 1 drops req after 3 beats while req[2]=1 -> release after the 3 beats. Next grant is gnt=4'b0100, not requester 0.
6. MAX_BURST=1, req=4'b0011 held -> grants alternate 0,1,0,1, one beat each, idle cycle between grants.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus between NUM_REQ requesters, the round-robin arbiter and one FIFO write port.
//   req       : per-requester write request (bit i = requester i)
//   din       : packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt       : registered one-hot grant
//   ack       : beat accepted this cycle
//   fifo_full : FIFO full flag
//   fifo_wen  : FIFO write enable
//   fifo_din  : FIFO write data
//   busy      : arbiter is in a burst
//   active_id : index of the granted requester
// The arbiter connects through the master modport; requesters/FIFO/testbench use slave.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] din;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          fifo_full;
    logic                          fifo_wen;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic                          busy;
    logic [IdW-1:0]                active_id;

    modport master (
        input  req, din, fifo_full,
        output gnt, ack, fifo_wen, fifo_din, busy, active_id
    );

    modport slave (
        output req, din, fifo_full,
        input  gnt, ack, fifo_wen, fifo_din, busy, active_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters. A grant lasts for
// up to MAX_BURST accepted beats or until the granted requester drops req; fifo_full stalls
// the burst without releasing it. One idle cycle always separates consecutive bursts.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_wr_arbiter_if master modport (req/din in, gnt/ack/fifo_* /busy/active_id out)
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_wr_arbiter_if.master   bus
);
    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IdW-1:0]      active_id_q, active_id_d;
    logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]    ack;
    logic                  cur_req;
    logic                  cur_ack;
    logic                  last_beat;
    logic                  sel_found;
    logic [IdW-1:0]        sel_id;
    logic [DATA_WIDTH-1:0] fifo_din;

    // First requesting index at or after rr_ptr, wrapping mod NUM_REQ. The outer loop is the
    // search order, so the earliest distance from rr_ptr wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!sel_found && bus.req[i] && (((32'(rr_ptr_q) + k) % NUM_REQ) == i)) begin
                    sel_found = 1'b1;
                    sel_id    = IdW'(i);
                end
            end
        end
    end

    // Gating with gnt_q makes ack/fifo_wen drop as soon as reset clears the grant.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            ack[i] = gnt_q[i] & bus.req[i] & ~bus.fifo_full;
        end
    end

    // Data follows active_id even while no beat is being written.
    always_comb begin
        fifo_din = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (active_id_q == IdW'(i)) begin
                fifo_din = bus.din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cur_req   = |(bus.req & gnt_q);
    assign cur_ack   = |ack;
    assign last_beat = (beat_cnt_q == CntW'(MAX_BURST - 1));

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        active_id_d = active_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        busy_d      = busy_q;
        unique case (state_q)
            StIdle: begin
                if (sel_found) begin
                    state_d     = StBurst;
                    active_id_d = sel_id;
                    beat_cnt_d  = '0;
                    busy_d      = 1'b1;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (sel_id == IdW'(i));
                    end
                end
            end
            StBurst: begin
                if (cur_ack) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A full FIFO only stalls; release comes from req dropping or the last beat.
                if (!cur_req || (cur_ack && last_beat)) begin
                    state_d    = StIdle;
                    gnt_d      = '0;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (active_id_q == IdW'(NUM_REQ - 1)) ? '0 : active_id_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            active_id_q <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            active_id_q <= active_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack;
    assign bus.fifo_wen  = cur_ack;
    assign bus.fifo_din  = fifo_din;
    assign bus.busy      = busy_q;
    assign bus.active_id = active_id_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: expected FIFO write data is queued when stimulus is driven and
// popped on every observed fifo_wen; grant/burst/gap records are checked per scenario.
// A second instance with MAX_BURST=1 covers single-beat bursts.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus1 ();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    typedef struct {
        int         id;
        logic [3:0] g;
        int         beats;
        int         gap;
    } grant_t;

    int          checks = 0;
    int          passes = 0;
    logic [15:0] base [NR];
    logic [15:0] seq  [NR];
    logic [15:0] exp_q [$];
    grant_t      grant_log [$];
    grant_t      cur;
    logic [3:0]  prev_gnt;
    int          gap;

    task automatic update_din();
        for (int i = 0; i < NR; i++) bus.din[i*DW +: DW] = base[i] + seq[i];
    endtask

    // One clock: at the falling edge pop/compare the scoreboard and log grants; after the
    // rising edge advance each requester whose beat was accepted.
    task automatic cycle();
        logic [3:0]  ack_seen;
        logic [15:0] e;
        @(negedge clk);
        if (bus.fifo_wen === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_write: fifo_din=%h with nothing expected",
                         bus.fifo_din);
            end else begin
                e = exp_q.pop_front();
                if (bus.fifo_din !== e)
                    $display("FAIL sb_data: fifo_din=%h expected %h", bus.fifo_din, e);
                else passes++;
            end
        end
        checks++;
        if ((bus.fifo_wen & bus.fifo_full) !== 1'b0)
            $display("FAIL write_while_full: fifo_wen=%b fifo_full=%b expected no write",
                     bus.fifo_wen, bus.fifo_full);
        else passes++;
        if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
            cur.id    = int'(bus.active_id);
            cur.g     = bus.gnt;
            cur.beats = 0;
            cur.gap   = gap;
        end
        if (bus.gnt != 4'b0 && bus.fifo_wen) cur.beats++;
        if (bus.gnt == 4'b0) begin
            if (prev_gnt != 4'b0) begin
                grant_log.push_back(cur);
                gap = 1;
            end else begin
                gap++;
            end
        end
        prev_gnt = bus.gnt;
        ack_seen = bus.ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (ack_seen[i]) seq[i] = seq[i] + 16'd1;
        update_din();
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        prev_gnt = 4'b0;
        gap      = 0;
        grant_log.delete();
    endtask

    task automatic test_reset();
        bus.req = 4'hF;
        update_din();
        #2;
        checks++; if (bus.gnt !== 4'b0) $display("FAIL reset_gnt: got %b expected 0000", bus.gnt);
        else passes++;
        checks++; if (bus.fifo_wen !== 1'b0) $display("FAIL reset_wen: got %b expected 0", bus.fifo_wen);
        else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
        else passes++;
        checks++; if (bus.active_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", bus.active_id);
        else passes++;
        for (int n = 0; n < 8; n++) exp_q.push_back(base[0] + seq[0] + 16'(n));
        rst_n = 1'b1;
        cycle();
        checks++; if (bus.gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt);
        else passes++;
        checks++; if (bus.busy !== 1'b1) $display("FAIL reset_first_busy: got %b expected 1", bus.busy);
        else passes++;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.gnt !== 4'b0) $display("FAIL reset_async_gnt: got %b expected 0000", bus.gnt);
        else passes++;
        checks++; if (bus.fifo_wen !== 1'b0) $display("FAIL reset_async_wen: got %b expected 0", bus.fifo_wen);
        else passes++;
        checks++; if (bus.ack !== 4'b0) $display("FAIL reset_async_ack: got %b expected 0000", bus.ack);
        else passes++;
        bus.req = 4'b0;
        #3;
        rst_n = 1'b1;
        exp_q.delete();
        grant_log.delete();
        prev_gnt = 4'b0;
        gap      = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_requester();
        grant_log.delete();
        base[2] = 16'h1000 - seq[2];
        update_din();
        for (int n = 0; n < 16; n++) exp_q.push_back(16'h1000 + 16'(n));
        bus.req = 4'b0100;
        cycle();
        checks++; if (bus.gnt !== 4'b0100) $display("FAIL single_gnt: got %b expected 0100", bus.gnt);
        else passes++;
        repeat (8) cycle();
        checks++; if (bus.gnt !== 4'b0) $display("FAIL single_release: got %b expected 0000", bus.gnt);
        else passes++;
        cycle();
        checks++; if (bus.gnt !== 4'b0100) $display("FAIL single_regrant: got %b expected 0100", bus.gnt);
        else passes++;
        repeat (8) cycle();
        bus.req = 4'b0;
        repeat (2) cycle();
        checks++;
        if (grant_log.size() != 2 || grant_log[0].beats != 8 || grant_log[1].beats != 8 ||
            grant_log[1].gap != 1)
            $display("FAIL single_bursts: %0d grants (beats %0d,%0d gap %0d) expected 2x8 gap 1",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0].beats : -1,
                     grant_log.size() > 1 ? grant_log[1].beats : -1,
                     grant_log.size() > 1 ? grant_log[1].gap : -1);
        else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL single_drain: %0d beats left expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int k [NR]    = '{0, 0, 0, 0};
        do_reset();
        update_din();
        for (int g = 0; g < 5; g++) begin
            for (int n = 0; n < 8; n++) begin
                exp_q.push_back(base[order[g]] + seq[order[g]] + 16'(k[order[g]]));
                k[order[g]]++;
            end
        end
        bus.req = 4'hF;
        repeat (45) cycle();
        bus.req = 4'b0;
        repeat (2) cycle();
        checks++; if (grant_log.size() != 5) $display("FAIL rr_count: got %0d grants expected 5", grant_log.size());
        else passes++;
        for (int g = 0; g < 5 && g < grant_log.size(); g++) begin
            checks++;
            if (grant_log[g].id != order[g] || grant_log[g].g !== (4'b0001 << order[g]) ||
                grant_log[g].beats != 8 || (g > 0 && grant_log[g].gap != 1))
                $display("FAIL rr_grant%0d: id %0d gnt %b beats %0d gap %0d expected id %0d 8 beats gap 1",
                         g, grant_log[g].id, grant_log[g].g, grant_log[g].beats, grant_log[g].gap,
                         order[g]);
            else passes++;
        end
        checks++; if (exp_q.size() != 0) $display("FAIL rr_drain: %0d beats left expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_backpressure();
        grant_log.delete();
        base[1] = 16'h2000 - seq[1];
        update_din();
        for (int n = 0; n < 8; n++) exp_q.push_back(16'h2000 + 16'(n));
        bus.req = 4'b0010;
        repeat (3) cycle();
        bus.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (bus.gnt !== 4'b0010 || bus.fifo_wen !== 1'b0 || bus.ack !== 4'b0)
                $display("FAIL bp_hold%0d: gnt %b wen %b ack %b expected 0010 0 0000",
                         c, bus.gnt, bus.fifo_wen, bus.ack);
            else passes++;
        end
        bus.fifo_full = 1'b0;
        repeat (6) cycle();
        bus.req = 4'b0;
        repeat (2) cycle();
        checks++;
        if (grant_log.size() != 1 || grant_log[0].id != 1 || grant_log[0].beats != 8)
            $display("FAIL bp_burst: %0d grants, beats %0d expected 1 grant of 8 to id 1",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0].beats : -1);
        else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL bp_drain: %0d beats left expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_early_drop();
        do_reset();
        base[1] = 16'h3000 - seq[1];
        base[2] = 16'h4000 - seq[2];
        update_din();
        for (int n = 0; n < 3; n++) exp_q.push_back(16'h3000 + 16'(n));
        for (int n = 0; n < 2; n++) exp_q.push_back(16'h4000 + 16'(n));
        bus.req = 4'b0110;
        cycle();
        checks++; if (bus.gnt !== 4'b0010) $display("FAIL drop_first_gnt: got %b expected 0010", bus.gnt);
        else passes++;
        bus.req = 4'b0111;
        repeat (3) cycle();
        bus.req = 4'b0101;
        cycle();
        checks++; if (bus.gnt !== 4'b0) $display("FAIL drop_release: got %b expected 0000", bus.gnt);
        else passes++;
        cycle();
        checks++; if (bus.gnt !== 4'b0100) $display("FAIL drop_next_gnt: got %b expected 0100", bus.gnt);
        else passes++;
        checks++; if (bus.active_id !== 2'd2) $display("FAIL drop_next_id: got %0d expected 2", bus.active_id);
        else passes++;
        repeat (2) cycle();
        bus.req = 4'b0;
        repeat (2) cycle();
        checks++;
        if (grant_log.size() != 2 || grant_log[0].id != 1 || grant_log[0].beats != 3 ||
            grant_log[1].id != 2 || grant_log[1].beats != 2 || grant_log[1].gap != 1)
            $display("FAIL drop_bursts: %0d grants, first id %0d beats %0d expected id1x3 then id2x2",
                     grant_log.size(), grant_log.size() > 0 ? grant_log[0].id : -1,
                     grant_log.size() > 0 ? grant_log[0].beats : -1);
        else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL drop_drain: %0d beats left expected 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_max_burst_one();
        logic [3:0]  exp_g [8] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                                   4'b0001, 4'b0000, 4'b0010, 4'b0000};
        logic [15:0] exp_d [8] = '{16'hA000, 16'h0, 16'hA001, 16'h0,
                                   16'hA000, 16'h0, 16'hA001, 16'h0};
        for (int i = 0; i < NR; i++) bus1.din[i*DW +: DW] = 16'hA000 + 16'(i);
        bus1.req = 4'b0011;
        for (int s = 0; s < 8; s++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus1.gnt !== exp_g[s] || bus1.ack !== exp_g[s])
                $display("FAIL mb1_step%0d: gnt %b ack %b expected %b", s, bus1.gnt, bus1.ack,
                         exp_g[s]);
            else passes++;
            if (exp_g[s] != 4'b0) begin
                checks++;
                if (bus1.fifo_wen !== 1'b1 || bus1.fifo_din !== exp_d[s])
                    $display("FAIL mb1_data%0d: wen %b din %h expected 1 %h", s, bus1.fifo_wen,
                             bus1.fifo_din, exp_d[s]);
                else passes++;
            end
        end
        bus1.req = 4'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req        = 4'b0;
        bus.fifo_full  = 1'b0;
        bus1.req       = 4'b0;
        bus1.fifo_full = 1'b0;
        bus1.din       = '0;
        prev_gnt       = 4'b0;
        gap            = 0;
        for (int i = 0; i < NR; i++) begin
            base[i] = 16'h0100 * 16'(i + 1);
            seq[i]  = 16'h0;
        end
        test_reset();
        test_single_requester();
        test_round_robin();
        test_backpressure();
        test_early_drop();
        test_max_burst_one();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
